// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame sequencer.
// Holds the state encoding, frame geometry constants and a state-class helper.
package uart_rx_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int START_BIT      = 0;
  localparam int FIRST_DATA     = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_CHECK  = 3'd5
  } rx_state_e;

  // States in which the edge/bit counters advance and the sampler is enabled.
  function automatic logic is_run_state(input rx_state_e s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_PARITY) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter.
// Counts edges 0..presc-1 within a bit and advances the bit index on each wrap.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cnt_en,
  input  logic [PRESC_W-1:0] presc,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               last_edge
);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [3:0]         r_bit_cnt;

  assign last_edge = (r_edge_cnt == (presc - PRESC_W'(1)));
  assign edge_cnt  = r_edge_cnt;
  assign bit_cnt   = r_bit_cnt;

  // A deasserted enable clears both counters, so idle and check cycles read zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!cnt_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (last_edge) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, bit timing, checker strobes
// and frame qualification (data_valid / frame_err).
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on RX_IN
// START  | start bit, strt_chk_en on its last edge
// DATA   | data bits LSB first, deser_en on each last edge
// PARITY | parity bit, par_chk_en on its last edge
// STOP   | stop bit, stp_chk_en on its last edge
// CHECK  | one cycle: report frame result, may chain straight into START
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               data_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               frame_err
);

  rx_state_e          r_state;
  rx_state_e          w_next_state;
  logic [PRESC_W-1:0] r_presc;
  logic               r_par_en;
  logic               r_par_flag;
  logic               r_stp_flag;
  logic               w_cnt_en;
  logic               w_last_edge;
  logic               w_frame_start;

  // Counting stops on the cycle the FSM leaves a run state, so CHECK/IDLE see zeros.
  assign w_cnt_en      = is_run_state(r_state) && is_run_state(w_next_state);
  assign w_frame_start = ((r_state == ST_IDLE) || (r_state == ST_CHECK)) &&
                         (w_next_state == ST_START);

  uart_rx_edge_bit_cnt #(.PRESC_W(PRESC_W)) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .cnt_en    (w_cnt_en),
    .presc     (r_presc),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (w_last_edge)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    data_samp_en = 1'b0;
    deser_en     = 1'b0;
    strt_chk_en  = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    data_valid   = 1'b0;
    frame_err    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!RX_IN) w_next_state = ST_START;
      end
      ST_START: begin
        data_samp_en = 1'b1;
        strt_chk_en  = w_last_edge;
        if (w_last_edge) w_next_state = strt_glitch ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        data_samp_en = 1'b1;
        deser_en     = w_last_edge;
        if (w_last_edge && (bit_cnt == 4'(DATA_WIDTH)))
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        data_samp_en = 1'b1;
        par_chk_en   = w_last_edge;
        if (w_last_edge) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        data_samp_en = 1'b1;
        stp_chk_en   = w_last_edge;
        if (w_last_edge) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        data_valid   = !(r_par_flag || r_stp_flag);
        frame_err    = r_par_flag || r_stp_flag;
        w_next_state = RX_IN ? ST_IDLE : ST_START;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame geometry is frozen at the start edge; later port changes apply to the next frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc  <= '0;
      r_par_en <= 1'b0;
    end else if (w_frame_start) begin
      r_presc  <= prescale;
      r_par_en <= PAR_EN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else begin
      if (par_chk_en && par_err) r_par_flag <= 1'b1;
      if (stp_chk_en && stp_err) r_stp_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the driver queues per-frame expectations,
// the monitor checks every strobe and frame result against frame timing arithmetic.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int PW = 6;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic [PW-1:0] prescale = 6'd8;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          data_valid, frame_err;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .data_samp_en(data_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int start;
    int p;
    bit par_en;
    bit glitch;
    bit perr;
    bit serr;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  bit     have_cur = 1'b0;
  int     n_deser = 0;
  int     n_par = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: frame timeline relative to 'start', the cycle in which the idle FSM
  // first sees the low line. Bit k ends at start+(k+1)*p; the result cycle follows the stop bit.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        have_cur = 1'b0;
        n_deser  = 0;
        n_par    = 0;
      end else begin
        if (data_valid || frame_err)
          chk("dv_fe_exclusive", int'(data_valid & frame_err), 0);
        if (strt_chk_en) begin
          chk("strt_while_busy", int'(have_cur), 0);
          chk("strt_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("strt_time", cyc, cur.start + cur.p);
            chk("strt_edge", int'(edge_cnt), cur.p - 1);
            chk("strt_bit", int'(bit_cnt), 0);
            chk("strt_samp_en", int'(data_samp_en), 1);
            have_cur = !cur.glitch;
            n_deser  = 0;
            n_par    = 0;
          end
        end
        if (deser_en) begin
          chk("deser_in_frame", int'(have_cur), 1);
          if (have_cur) begin
            n_deser++;
            chk("deser_bit", int'(bit_cnt), n_deser);
            chk("deser_time", cyc, cur.start + (n_deser + 1) * cur.p);
            chk("deser_edge", int'(edge_cnt), cur.p - 1);
          end
        end
        if (par_chk_en) begin
          chk("par_in_frame", int'(have_cur), 1);
          if (have_cur) begin
            n_par++;
            chk("par_enabled", int'(cur.par_en), 1);
            chk("par_bit", int'(bit_cnt), DW + 1);
            chk("par_edge", int'(edge_cnt), cur.p - 1);
            chk("par_time", cyc, cur.start + (DW + 2) * cur.p);
          end
        end
        if (stp_chk_en) begin
          chk("stp_in_frame", int'(have_cur), 1);
          if (have_cur) begin
            chk("stp_bit", int'(bit_cnt), DW + 1 + int'(cur.par_en));
            chk("stp_time", cyc, cur.start + (DW + 2 + int'(cur.par_en)) * cur.p);
          end
        end
        if (data_valid || frame_err) begin
          chk("result_in_frame", int'(have_cur), 1);
          if (have_cur) begin
            bit bad;
            bad = (cur.par_en & cur.perr) | cur.serr;
            chk("result_time", cyc, cur.start + 1 + (DW + 2 + int'(cur.par_en)) * cur.p);
            chk("data_valid", int'(data_valid), int'(!bad));
            chk("frame_err", int'(frame_err), int'(bad));
            chk("deser_count", n_deser, DW);
            chk("par_count", n_par, int'(cur.par_en));
            chk("check_samp_en", int'(data_samp_en), 0);
            chk("check_counters", int'({edge_cnt, bit_cnt}), 0);
            have_cur = 1'b0;
          end
        end
      end
    end
  end

  // Drives one frame on the line. Called #1 after a posedge; returns at the end of the stop
  // bit, aligned so that a back-to-back caller's start low lands in the stop bit's last cycle.
  task automatic send_frame(input int p, input bit pe, input logic [7:0] data, input bit gl,
                            input bit perr, input bit serr, input bit b2b, input bit scramble);
    frame_t f;
    RX_IN = 1'b0;
    if (b2b) tick(1);
    prescale    = PW'(p);
    PAR_EN      = pe;
    strt_glitch = gl;
    par_err     = perr;
    stp_err     = serr;
    f.start = cyc; f.p = p; f.par_en = pe; f.glitch = gl; f.perr = perr; f.serr = serr;
    exp_q.push_back(f);
    tick(2);
    if (gl) begin
      RX_IN = 1'b1;
      tick(p + 1);
      return;
    end
    if (scramble) begin
      prescale = PW'(8 + 2 * $urandom_range(0, 12));
      PAR_EN   = $urandom_range(0, 1) != 0;
    end
    tick(p - 2 - int'(b2b));
    for (int i = 0; i < DW; i++) begin
      RX_IN = data[i];
      tick(p);
    end
    if (pe) begin
      RX_IN = ^data;
      tick(p);
    end
    RX_IN = 1'b1;
    tick(p + int'(b2b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    bit prev_gl;
    RST = 1'b0;
    tick(3);
    chk("reset_outputs", int'({data_samp_en, edge_cnt, bit_cnt, deser_en, strt_chk_en,
                               par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
    RST = 1'b1;
    tick(3);

    send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(4);
    send_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    send_frame(32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(32, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(4);

    // Reset in the middle of data bit 4, then a clean frame afterwards.
    RX_IN = 1'b0; prescale = PW'(8); PAR_EN = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    st = cyc;
    exp_q.push_back('{start: st, p: 8, par_en: 1'b0, glitch: 1'b0, perr: 1'b0, serr: 1'b0});
    tick(4 * 8 + 3);
    chk("pre_reset_bit", int'(bit_cnt), 4);
    RST = 1'b0;
    #1;
    chk("midframe_reset_outputs", int'({data_samp_en, edge_cnt, bit_cnt, deser_en, strt_chk_en,
                                        par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
    RX_IN = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(3);
    send_frame(10, 1'b1, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    prev_gl = 1'b0;
    for (int n = 0; n < 20; n++) begin
      int  p;
      bit  pe, gl, b2b;
      p   = 8 + 2 * $urandom_range(0, 12);
      pe  = $urandom_range(0, 1) != 0;
      gl  = $urandom_range(0, 7) == 0;
      b2b = !gl && !prev_gl && ($urandom_range(0, 2) == 0);
      if (!b2b) tick($urandom_range(2, 6));
      send_frame(p, pe, 8'($urandom), gl, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, b2b, 1'b1);
      prev_gl = gl;
    end

    tick(400);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("frame_unfinished", int'(have_cur), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
